uart_cmd_parser: RTL
====================

# uart_cmd_parser

Byte-stream command framer placed directly downstream of the UART receiver. Consumes received bytes (valid strobe, data, break flag), assembles fixed 5-byte command frames, verifies an XOR checksum and issues single-cycle register read/write strobes to the control register bank. Malformed, truncated or stalled frames are discarded with an error pulse and code.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- OP_WRITE, 8'h01, write opcode.
- OP_READ, 8'h02, read opcode.
- TIMEOUT_CYCLES, 1_000_000, max idle clk cycles between bytes inside a frame; must be ≥2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte this cycle.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- rx_break  in  1  coincident with rx_valid: byte was a BREAK.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_addr  out  8  address; held until next strobe.
- reg_wdata  out  8  write data; held until next strobe.
- busy  out  1  high while a frame is partially received.
- err  out  1  one-cycle error pulse.
- err_code  out  2  1=checksum, 2=bad opcode, 3=timeout; held until next err.

## Operation

- Frame: SYNC, OP, ADDR, DATA, CSUM; CSUM = OP ^ ADDR ^ DATA. Read frames carry a DATA byte (ignored).
- States: HUNT, OP, ADDR, DATA, CSUM. Each rx_valid advances one state; CSUM returns to HUNT.
- HUNT: non-SYNC bytes are dropped silently; SYNC -> OP.
- OP/ADDR/DATA: byte latched into internal shadow regs; reg_addr/reg_wdata change only on issue.
- CSUM byte: match and OP_WRITE -> reg_wr_en; match and OP_READ -> reg_rd_en; match with other opcode -> err, code 2; mismatch -> err, code 1 (checksum priority over opcode). Always back to HUNT.
- rx_break with rx_valid in any state: return to HUNT, no strobe, no err; break byte never counts as SYNC.
- Timeout: counter cleared on every rx_valid and in HUNT; increments otherwise. After TIMEOUT_CYCLES cycles without rx_valid outside HUNT: err, code 3, -> HUNT. rx_valid in the expiry cycle wins (byte accepted, no timeout).
- busy = state != HUNT.
- Reset: state HUNT; all outputs 0 (reg_addr, reg_wdata, err_code = 0); counter 0. Reset mid-frame discards the partial frame, no err.

## Timing

- Strobes/err assert exactly one cycle after the rx_valid carrying CSUM; registered outputs, no combinational input-to-output path.
- reg_addr/reg_wdata update in the same cycle as the strobe and stay stable afterward.
- Back-to-back frames: new SYNC may arrive the cycle after CSUM; a byte on every clk cycle must be handled without loss.
- Timeout err asserts in the cycle after the TIMEOUT_CYCLES-th idle cycle.
- reg_wr_en, reg_rd_en, err mutually exclusive.

## Structure

- Shared package/include uart_cmd_pkg: state encoding, error-code constants (ERR_NONE/CSUM/OPCODE/TIMEOUT), default opcodes and SYNC value.
- Sub-module uart_timeout_timer: clear/enable inputs, expiry pulse, width $clog2(TIMEOUT_CYCLES)+1.
- Top: FSM, shadow regs, checksum accumulator, output registers.

## Test plan

- Write: A5 01 10 5C 4D -> reg_wr_en one cycle, reg_addr=10, reg_wdata=5C, err=0.
- Read: A5 02 20 00 22 -> reg_rd_en one cycle, reg_addr=20, reg_wdata unchanged.
- Bad checksum: A5 01 10 5C 00 -> err, err_code=1, no strobe; bad opcode A5 07 10 5C 4B -> err, err_code=2.
- Junk then frame: 00 FF A5 01 10 5C 4D -> exactly one write; break after A5 01 -> HUNT, no err, busy=0.
- Timeout (TIMEOUT_CYCLES=16): A5 01 then 16 idle cycles -> err, err_code=3; byte at cycle 16 instead -> no err, frame continues.
- Reset asserted after A5 01 10, then full valid frame -> one correct write only, outputs 0 during reset.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command framer: frame-parser state
// encoding, error-code constants, default opcodes / SYNC marker and the
// checksum step helper used by the parser's running XOR accumulator.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  // Frame parser states; one state per byte position in the 5-byte frame.
  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_OP   = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  // Error codes reported on err_code (held until the next err pulse).
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_OPCODE  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Default frame marker and opcodes.
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_OP_WRITE  = 8'h01;
  localparam logic [7:0] DEF_OP_READ   = 8'h02;

  // One step of the frame checksum: XOR-fold a payload byte into the
  // accumulator.
  function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                           input logic [7:0] data_byte);
    csum_step = acc ^ data_byte;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// ---------------------------------------------------------------------------
// uart_timeout_timer
// Inter-byte idle counter for the command framer. The count is cleared
// whenever clear_i is high and advances on each enabled cycle. expire_o
// flags the enabled cycle that completes TIMEOUT_CYCLES idle cycles, so the
// owner can register its timeout reaction on that same edge.
//
// Ports:
//   clk       in  system clock
//   resetn    in  synchronous, active-low reset
//   clear_i   in  force count to zero (takes priority over enable_i)
//   enable_i  in  count this cycle as idle
//   expire_o  out high on the TIMEOUT_CYCLES-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module uart_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES) + 1;
  // Count value already reached when the final idle cycle is in progress.
  localparam logic [W-1:0] LAST_CNT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire_o = enable_i && !clear_i && (cnt_q == LAST_CNT);

  // Saturate at LAST_CNT so a stuck enable never wraps back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
// Byte-stream command framer downstream of the UART receiver. Assembles
// 5-byte frames (SYNC, OP, ADDR, DATA, CSUM with CSUM = OP^ADDR^DATA),
// verifies the checksum and issues one-cycle register read/write strobes.
// Bad checksums, unknown opcodes and stalled frames raise a one-cycle err
// pulse with a held err_code. A BREAK byte silently aborts any frame.
//
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous, active-low reset
//   rx_valid   in   one-cycle strobe: rx_data carries a new byte
//   rx_data    in   received byte (8 bits)
//   rx_break   in   with rx_valid: byte was a BREAK
//   reg_wr_en  out  one-cycle write strobe
//   reg_rd_en  out  one-cycle read strobe
//   reg_addr   out  address (8 bits), held until next strobe
//   reg_wdata  out  write data (8 bits), held until next write strobe
//   busy       out  a frame is partially received
//   err        out  one-cycle error pulse
//   err_code   out  1=checksum, 2=bad opcode, 3=timeout; held until next err
// ---------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  OP_WRITE       = DEF_OP_WRITE,
  parameter logic [7:0]  OP_READ        = DEF_OP_READ,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_break,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  state_e     state_q;
  logic [7:0] op_q;        // shadow: opcode of frame in flight
  logic [7:0] addr_sh_q;   // shadow: address of frame in flight
  logic [7:0] wdata_sh_q;  // shadow: data byte of frame in flight
  logic [7:0] csum_q;      // running XOR of payload bytes
  logic [7:0] csum_d;

  logic       wr_en_q;
  logic       rd_en_q;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       err_q;
  logic [1:0] err_code_q;

  logic       tmr_clear_s;
  logic       tmr_enable_s;
  logic       tmr_expire_s;

  // Idle time is only meaningful inside a frame; any received byte restarts it.
  assign tmr_enable_s = (state_q != ST_HUNT) && !rx_valid;
  assign tmr_clear_s  = !tmr_enable_s;

  uart_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .clear_i  (tmr_clear_s),
    .enable_i (tmr_enable_s),
    .expire_o (tmr_expire_s)
  );

  assign csum_d = csum_step(csum_q, rx_data);

  // Frame FSM with shadow registers, checksum accumulator and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_HUNT;
      op_q        <= 8'h00;
      addr_sh_q   <= 8'h00;
      wdata_sh_q  <= 8'h00;
      csum_q      <= 8'h00;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      // Strobes and err are single-cycle pulses.
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;

      if (rx_valid) begin
        if (rx_break) begin
          // BREAK aborts silently and is never taken as a SYNC.
          state_q <= ST_HUNT;
        end else begin
          case (state_q)
            ST_HUNT: begin
              if (rx_data == SYNC_BYTE) begin
                state_q <= ST_OP;
              end else begin
                state_q <= ST_HUNT;
              end
            end
            ST_OP: begin
              op_q    <= rx_data;
              csum_q  <= rx_data;  // first payload byte seeds the accumulator
              state_q <= ST_ADDR;
            end
            ST_ADDR: begin
              addr_sh_q <= rx_data;
              csum_q    <= csum_d;
              state_q   <= ST_DATA;
            end
            ST_DATA: begin
              wdata_sh_q <= rx_data;
              csum_q     <= csum_d;
              state_q    <= ST_CSUM;
            end
            ST_CSUM: begin
              // Checksum failure is reported ahead of an unknown opcode.
              if (csum_q != rx_data) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_CSUM;
              end else if (op_q == OP_WRITE) begin
                wr_en_q     <= 1'b1;
                reg_addr_q  <= addr_sh_q;
                reg_wdata_q <= wdata_sh_q;
              end else if (op_q == OP_READ) begin
                rd_en_q    <= 1'b1;
                reg_addr_q <= addr_sh_q;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= ERR_OPCODE;
              end
              state_q <= ST_HUNT;
            end
            default: begin
              state_q <= ST_HUNT;
            end
          endcase
        end
      end else if (tmr_expire_s) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= ST_HUNT;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_HUNT);

endmodule
